// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: run-time pattern modes and
// bounce direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_BINARY   = 2'd0,
        MODE_PRIORITY = 2'd1,
        MODE_CHASE    = 2'd2,
        MODE_BOUNCE   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/led_sequencer_prescaler.sv
// Step prescaler: one tick every div+1 enabled cycles. The >= compare makes
// a mid-count reduction of div tick on the next enabled cycle.
module tick_prescaler #(
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] presc_cnt;

    assign tick = enable && (presc_cnt >= div);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_cnt <= '0;
        end else if (enable) begin
            if (presc_cnt >= div) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// Generic N-LED pattern generator: four pattern engines advanced by a shared
// prescaler tick, a run-time mode mux and a PWM brightness gate.
module led_sequencer
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 3,
    parameter int unsigned DIV_WIDTH = 24,
    parameter int unsigned PWM_WIDTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic [PWM_WIDTH-1:0] brightness,
    output logic [NUM_LEDS-1:0]  leds,
    output logic                 step_pulse
);

    localparam int unsigned POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    logic                 tick;
    logic [NUM_LEDS-1:0]  seq_cnt, seq_nxt;
    logic [NUM_LEDS-1:0]  chase, chase_nxt;
    logic [POS_W-1:0]     bounce_pos, pos_nxt;
    dir_e                 bounce_dir, dir_nxt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic [NUM_LEDS-1:0]  pattern;
    logic                 gate;

    tick_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .enable   (enable),
        .div      (div),
        .tick     (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            seq_cnt    <= '0;
            chase      <= NUM_LEDS'(1);
            bounce_pos <= '0;
            bounce_dir <= DIR_UP;
            pwm_cnt    <= '0;
            leds       <= '0;
            step_pulse <= 1'b0;
        end else begin
            seq_cnt    <= seq_nxt;
            chase      <= chase_nxt;
            bounce_pos <= pos_nxt;
            bounce_dir <= dir_nxt;
            pwm_cnt    <= pwm_cnt + PWM_WIDTH'(1);
            leds       <= pattern & {NUM_LEDS{gate}};
            step_pulse <= tick;
        end
    end

    always_comb begin
        seq_nxt   = seq_cnt;
        chase_nxt = chase;
        pos_nxt   = bounce_pos;
        dir_nxt   = bounce_dir;
        if (tick) begin
            seq_nxt   = seq_cnt + NUM_LEDS'(1);
            chase_nxt = (chase << 1) | (chase >> (NUM_LEDS - 1));
            if (NUM_LEDS > 1) begin
                if (bounce_dir == DIR_UP) begin
                    if (bounce_pos == POS_LAST) begin
                        dir_nxt = DIR_DOWN;
                        pos_nxt = bounce_pos - POS_W'(1);
                    end else begin
                        pos_nxt = bounce_pos + POS_W'(1);
                    end
                end else begin
                    if (bounce_pos == '0) begin
                        dir_nxt = DIR_UP;
                        pos_nxt = POS_W'(1);
                    end else begin
                        pos_nxt = bounce_pos - POS_W'(1);
                    end
                end
            end
        end
    end

    // The mux looks at post-tick engine state so leds shows a new step on
    // the same edge that raises step_pulse.
    always_comb begin
        pattern = '0;
        case (mode_e'(mode))
            MODE_BINARY:   pattern = seq_nxt;
            MODE_PRIORITY: pattern = seq_nxt & (~seq_nxt + NUM_LEDS'(1));
            MODE_CHASE:    pattern = chase_nxt;
            MODE_BOUNCE:   pattern = NUM_LEDS'(1) << pos_nxt;
            default:       pattern = '0;
        endcase
    end

    assign gate = (brightness == '1) || (pwm_cnt < brightness);

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer (3 LEDs): pattern sequences, PWM duty,
// asynchronous reset and prescaler boundary behaviour.
module tb_led_sequencer;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        enable     = 1'b0;
    logic [1:0]  mode       = 2'd0;
    logic [23:0] div        = 24'd3;
    logic [3:0]  brightness = 4'd15;
    logic [2:0]  leds;
    logic        step_pulse;

    int unsigned checks = 0;
    int unsigned passes = 0;
    int unsigned fails  = 0;

    logic [2:0] bin_exp [9]   = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001};
    logic [2:0] pri_exp [8]   = '{3'b001, 3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b000};
    logic [2:0] chase_exp [4] = '{3'b010, 3'b100, 3'b001, 3'b010};
    logic [2:0] bnc_exp [5]   = '{3'b010, 3'b100, 3'b010, 3'b001, 3'b010};

    led_sequencer #(
        .NUM_LEDS (3),
        .DIV_WIDTH(24),
        .PWM_WIDTH(4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .enable    (enable),
        .mode      (mode),
        .div       (div),
        .brightness(brightness),
        .leds      (leds),
        .step_pulse(step_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Reset asserted between edges, checked before any edge, released just after an edge.
    task automatic do_reset();
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("rst_leds", 32'(leds), 32'd0);
        check("rst_step", 32'(step_pulse), 32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned n;
        int unsigned ones;
        int unsigned hi_bits;
        int unsigned pulses;

        step();
        check("reset_leds", 32'(leds), 32'd0);
        check("reset_step", 32'(step_pulse), 32'd0);

        // BINARY, div=3
        mode = 2'd0; div = 24'd3; brightness = 4'd15; enable = 1'b1;
        sys_rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                check("bin_idle", 32'(step_pulse), 32'd0);
            end
            step();
            check("bin_pulse", 32'(step_pulse), 32'd1);
            check("bin_leds", 32'(leds), 32'(bin_exp[k]));
        end

        // PRIORITY, div=3
        mode = 2'd1;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            repeat (3) step();
            step();
            check("pri_pulse", 32'(step_pulse), 32'd1);
            check("pri_leds", 32'(leds), 32'(pri_exp[k]));
        end

        // CHASE, div=0, then switch to BOUNCE mid-run
        mode = 2'd2; div = 24'd0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            check("chase_pulse", 32'(step_pulse), 32'd1);
            check("chase_leds", 32'(leds), 32'(chase_exp[k]));
        end
        mode = 2'd3;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bnc_mid_pulse", 32'(step_pulse), 32'd1);
            check("bnc_mid_leds", 32'(leds), 32'(bnc_exp[k]));
        end

        // BOUNCE from reset (reset lands while step_pulse and leds are active)
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            check("bnc_leds", 32'(leds), 32'(bnc_exp[k]));
        end

        // PWM with frozen CHASE (bit 0 lit)
        enable = 1'b0; mode = 2'd2; brightness = 4'd4;
        do_reset();
        step();
        ones = 0; hi_bits = 0; pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            ones    += 32'(leds[0]);
            hi_bits += 32'(leds[2:1] != 2'b00);
            pulses  += 32'(step_pulse);
        end
        check("pwm4_on", ones, 32'd4);
        check("pwm4_upper", hi_bits, 32'd0);
        check("freeze_no_step", pulses, 32'd0);

        brightness = 4'd0;
        step();
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            ones += 32'(leds != 3'b000);
        end
        check("pwm0_on", ones, 32'd0);

        brightness = 4'd15;
        step();
        ones = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            ones += 32'(leds[0]);
        end
        check("pwm15_on", ones, 32'd16);

        // First tick after reset release with div=5
        div = 24'd5; enable = 1'b1;
        do_reset();
        n = 0;
        do begin
            step();
            n++;
        end while (!step_pulse && n < 20);
        check("rst_latency", n, 32'd6);

        // Lowering div below presc_cnt
        div = 24'd10;
        do_reset();
        repeat (7) step();
        check("div_before", 32'(step_pulse), 32'd0);
        div = 24'd2;
        step();
        check("div_lower_pulse", 32'(step_pulse), 32'd1);
        check("div_lower_leds", 32'(leds), 32'b010);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
